bfly_stage_ctrl: RTL

Sequencer for one radix-2 butterfly stage of the FFT datapath. It replaces the free-running beat counter inside the stage with an explicit FSM. Each frame is `COUNT` input beats. The first `HALF` beats are steered into the delay shift register. The next `HALF` beats drive the butterfly together with the delayed samples, and the controller flags the matching outputs after the butterfly pipeline latency. It tolerates gaps in `valid_in`, supports back-to-back frames and provides a synchronous flush.

---
 rtl/bfly_ctrl_pkg.sv | 22 ++
 rtl/bfly_valid_pipe.sv | 71 +++++++
 rtl/bfly_stage_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/bfly_ctrl_pkg.sv
// Shared definitions for the radix-2 butterfly stage sequencer.
//   bfly_state_t : sequencer states (IDLE, FILL, COMPUTE)
//   bfly_half()  : butterfly span in beats for a given frame size and lane count
//   bfly_cw()    : counter width for a span, never narrower than one bit
package bfly_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    COMPUTE = 2'd2
  } bfly_state_t;

  function automatic int bfly_half(input int data, input int num);
    return (data / num) / 2;
  endfunction

  // A span of one beat still needs a 1-bit counter/index to keep ports legal.
  function automatic int bfly_cw(input int half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/bfly_valid_pipe.sv
// Fixed-latency tracking pipe for butterfly results.
// Carries {valid, idx, last} through LAT register stages so the flags line up
// with the butterfly datapath output.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   clr                  : synchronous clear of every stage (frame abort)
//   enq_valid/idx/last   : stage-0 inputs, sampled every cycle
//   deq_valid/idx/last   : last-stage register outputs
//   occupied             : any stage holds a valid entry
module bfly_valid_pipe #(
  parameter int LAT = 3,
  parameter int IW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          enq_valid,
  input  logic [IW-1:0] enq_idx,
  input  logic          enq_last,
  output logic          deq_valid,
  output logic [IW-1:0] deq_idx,
  output logic          deq_last,
  output logic          occupied
);

  logic [LAT-1:0] valid_reg;
  logic [LAT-1:0] valid_next;
  logic [LAT-1:0] last_reg;
  logic [LAT-1:0] last_next;
  logic [IW-1:0]  idx_reg  [LAT];
  logic [IW-1:0]  idx_next [LAT];

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_next[gi] = enq_valid;
        assign idx_next[gi]   = enq_idx;
        assign last_next[gi]  = enq_last;
      end else begin : g_body
        assign valid_next[gi] = valid_reg[gi-1];
        assign idx_next[gi]   = idx_reg[gi-1];
        assign last_next[gi]  = last_reg[gi-1];
      end
    end
  endgenerate

  // clr only drops the flags; the stale indices are never seen without valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      last_reg  <= '0;
      for (int i = 0; i < LAT; i++) begin
        idx_reg[i] <= '0;
      end
    end else if (clr) begin
      valid_reg <= '0;
      last_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      last_reg  <= last_next;
      idx_reg   <= idx_next;
    end
  end

  assign deq_valid = valid_reg[LAT-1];
  assign deq_idx   = idx_reg[LAT-1];
  assign deq_last  = last_reg[LAT-1];
  assign occupied  = |valid_reg;

endmodule

// File: rtl/bfly_stage_ctrl.sv
// Sequencer for one radix-2 butterfly stage.
// The first HALF beats of a frame go into the delay shift register, the next
// HALF beats are combined with the delayed beats in the butterfly, and the
// matching outputs are flagged BFLY_LAT cycles later.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   valid_in    : one input beat this cycle
//   flush       : synchronous abort of the current frame (beats valid_in)
//   sr_write    : shift register captures the current beat
//   sr_read     : shift register presents its oldest beat
//   bfly_en     : butterfly consumes current beat plus delayed beat
//   valid_out   : butterfly outputs valid this cycle
//   out_idx     : pair index of the beat under valid_out
//   frame_done  : coincides with the last valid_out of a frame
//   busy        : frame in progress or results still in flight
module bfly_stage_ctrl
  import bfly_ctrl_pkg::*;
#(
  parameter int NUM      = 16,
  parameter int DATA     = 512,
  parameter int COUNT    = DATA / NUM,
  parameter int HALF     = bfly_half(DATA, NUM),
  parameter int BFLY_LAT = 3,
  localparam int CW      = bfly_cw(HALF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic          flush,
  output logic          sr_write,
  output logic          sr_read,
  output logic          bfly_en,
  output logic          valid_out,
  output logic [CW-1:0] out_idx,
  output logic          frame_done,
  output logic          busy
);

  // Both halves are COUNT-HALF == HALF beats long, so one terminal value serves.
  localparam logic [CW-1:0] LAST_BEAT = CW'(COUNT - HALF - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  bfly_state_t   state_reg;
  bfly_state_t   state_next;
  logic [CW-1:0] beat_cnt_reg;
  logic [CW-1:0] beat_cnt_next;

  logic accept;
  logic last_beat;
  logic last_flag;
  logic pipe_busy;

  assign last_beat = (beat_cnt_reg == LAST_BEAT);

  // Gating with rst keeps the steering quiet while reset is held, even though
  // valid_in may already be toggling.
  assign accept    = valid_in & ~flush & ~rst;
  assign sr_write  = accept & (state_reg != COMPUTE);
  assign bfly_en   = accept & (state_reg == COMPUTE);
  assign sr_read   = bfly_en;
  assign last_flag = bfly_en & last_beat;

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    if (flush) begin
      state_next    = IDLE;
      beat_cnt_next = '0;
    end else if (valid_in) begin
      case (state_reg)
        IDLE: begin
          // The IDLE beat is beat 0, so FILL resumes counting at 1.
          if (HALF == 1) begin
            state_next    = COMPUTE;
            beat_cnt_next = '0;
          end else begin
            state_next    = FILL;
            beat_cnt_next = ONE;
          end
        end
        FILL: begin
          if (last_beat) begin
            state_next    = COMPUTE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + ONE;
          end
        end
        COMPUTE: begin
          // Returning to IDLE here lets the very next beat start a new frame.
          if (last_beat) begin
            state_next    = IDLE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + ONE;
          end
        end
        default: begin
          state_next    = IDLE;
          beat_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  bfly_valid_pipe #(
    .LAT (BFLY_LAT),
    .IW  (CW)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .enq_valid (bfly_en),
    .enq_idx   (beat_cnt_reg),
    .enq_last  (last_flag),
    .deq_valid (valid_out),
    .deq_idx   (out_idx),
    .deq_last  (frame_done),
    .occupied  (pipe_busy)
  );

  assign busy = (state_reg != IDLE) | pipe_busy;

endmodule
